// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware byte FIFO with occupancy, error flags and read-side packet tracking
module router_fifo_pkt #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      soft_reset,
  input  logic                      write_enb,
  input  logic                      lfd_state,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      read_enb,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  output logic                      pkt_last,
  output logic                      pkt_busy,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      ovf_err,
  output logic                      udf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LEN_W = DATA_W - 2;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LVL);
  localparam logic [LEN_W:0] LEN_ONE = (LEN_W+1)'(1);
  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W:0] rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, ovf_q, ovf_d, udf_q, udf_d;
  logic clr, wr_ok, rd_ok;
  logic [DATA_W:0] rd_entry;
  // Occupancy is the pointer distance; the extra pointer bit separates full from empty
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = count == '0;
  assign full = count == DEPTH_C;
  assign almost_full = count >= AF_C;
  assign pkt_busy = rem_q != '0;
  assign data_out = data_q;
  assign data_valid = valid_q;
  assign pkt_last = last_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
  // Next state: accepts, pointer advance, packet remaining-byte tracking and sticky errors
  always_comb begin
    clr = reset | soft_reset;
    wr_ok = write_enb & ~full;
    rd_ok = read_enb & ~empty;
    rd_entry = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = clr ? '0 : wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = clr ? '0 : rd_ptr_q + {{AW{1'b0}}, rd_ok};
    rem_d = clr ? '0 :
            !rd_ok ? rem_q :
            rd_entry[DATA_W] ? {1'b0, rd_entry[DATA_W-1:2]} + LEN_ONE :
            rem_q != '0 ? rem_q - LEN_ONE : rem_q;
    data_d = clr ? '0 : rd_ok ? rd_entry[DATA_W-1:0] : data_q;
    valid_d = ~clr & rd_ok;
    last_d = ~clr & rd_ok & ~rd_entry[DATA_W] & (rem_q == LEN_ONE);
    ovf_d = ~clr & (ovf_q | (write_enb & full));
    udf_d = ~clr & (udf_q | (read_enb & empty));
  end
  // State register; both resets are folded into the next-state logic
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    rem_q <= rem_d;
    data_q <= data_d;
    valid_q <= valid_d;
    last_q <= last_d;
    ovf_q <= ovf_d;
    udf_q <= udf_d;
  end
  // Storage array is not reset; a write in a clearing cycle is discarded
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end
endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: directed stimulus with a scoreboard queue checked by a read-data monitor
module tb_router_fifo_pkt;
  logic clk = 0, reset = 1, soft_reset = 0, write_enb = 0, lfd_state = 0, read_enb = 0;
  logic [7:0] data_in = 0, data_out;
  logic data_valid, pkt_last, pkt_busy, empty, full, almost_full, ovf_err, udf_err;
  logic [4:0] count;
  int checks = 0, failures = 0;
  logic [8:0] exp_q [$];

  router_fifo_pkt #(.DATA_W(8), .DEPTH(16), .AF_LVL(14)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .data_valid(data_valid), .pkt_last(pkt_last), .pkt_busy(pkt_busy), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%h last=%b expected no read data", data_out, pkt_last);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({pkt_last, data_out} !== e) begin
          failures++;
          $display("FAIL rd_data got last=%b data=%h expected last=%b data=%h", pkt_last, data_out, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic l, input logic [7:0] d);
    write_enb = 1; lfd_state = l; data_in = d;
    step();
    write_enb = 0; lfd_state = 0;
  endtask

  task automatic rd(input logic [7:0] d, input logic last);
    read_enb = 1;
    exp_q.push_back({last, d});
    step();
    read_enb = 0;
  endtask

  task automatic srst();
    soft_reset = 1;
    step();
    soft_reset = 0;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_count"}, 32'(count), 0);
    chk({n, "_flags"}, {empty, full, almost_full, pkt_busy, data_valid, pkt_last, ovf_err, udf_err}, 8'b1000_0000);
    chk({n, "_dout"}, 32'(data_out), 0);
  endtask

  initial begin
    step(); step();
    reset = 0;
    chk_reset_vals("reset");
    // basic packet: header len 3, three payload, parity
    wr(1, 8'h0C); wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h44);
    chk("t1_count", 32'(count), 5);
    rd(8'h0C, 0);
    chk("t1_busy_hdr", 32'(pkt_busy), 1);
    rd(8'h11, 0); rd(8'h22, 0); rd(8'h33, 0);
    chk("t1_busy_mid", 32'(pkt_busy), 1);
    rd(8'h44, 1);
    chk("t1_busy_end", 32'(pkt_busy), 0);
    chk("t1_empty", 32'(empty), 1);
    // fill to full, overflow, drain
    for (int i = 0; i < 16; i++) begin
      wr(0, 8'(8'hA0 + i));
      chk("t2_count", 32'(count), 32'(i + 1));
      chk("t2_af", 32'(almost_full), (i + 1 >= 14) ? 1 : 0);
      chk("t2_full", 32'(full), (i + 1 == 16) ? 1 : 0);
    end
    chk("t2_ovf_pre", 32'(ovf_err), 0);
    wr(0, 8'hFF);
    chk("t2_ovf", 32'(ovf_err), 1);
    chk("t2_count_ovf", 32'(count), 16);
    for (int i = 0; i < 16; i++) rd(8'(8'hA0 + i), 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_udf", 32'(udf_err), 0);
    // simultaneous read/write at count 8, pointers wrap
    for (int i = 0; i < 8; i++) wr(0, 8'(8'h50 + i));
    for (int i = 0; i < 20; i++) begin
      write_enb = 1; data_in = 8'(8'h58 + i);
      rd(8'(8'h50 + i), 0);
      write_enb = 0;
      chk("t3_count_rw", 32'(count), 8);
    end
    for (int i = 28; i < 36; i++) wr(0, 8'(8'h50 + i));
    chk("t3_full", 32'(full), 1);
    write_enb = 1; data_in = 8'hEE;
    rd(8'h64, 0);
    write_enb = 0;
    chk("t3_count_full_rw", 32'(count), 15);
    for (int i = 21; i < 36; i++) rd(8'(8'h50 + i), 0);
    chk("t3_empty", 32'(empty), 1);
    // read while empty
    read_enb = 1;
    step();
    read_enb = 0;
    chk("t4_valid", 32'(data_valid), 0);
    chk("t4_dout_hold", 32'(data_out), 32'h73);
    chk("t4_udf", 32'(udf_err), 1);
    srst();
    chk_reset_vals("t4_srst");
    // soft reset mid-packet, then fresh packets from index 0
    wr(1, 8'h14);
    for (int i = 1; i <= 6; i++) wr(0, 8'(i));
    rd(8'h14, 0); rd(8'h01, 0); rd(8'h02, 0);
    chk("t5_busy", 32'(pkt_busy), 1);
    chk("t5_count", 32'(count), 4);
    srst();
    chk_reset_vals("t5_srst");
    wr(1, 8'h08); wr(0, 8'h77); wr(0, 8'h88); wr(0, 8'h99);
    wr(1, 8'h03); wr(0, 8'h5A);
    rd(8'h08, 0); rd(8'h77, 0); rd(8'h88, 0); rd(8'h99, 1);
    rd(8'h03, 0);
    chk("t5_busy_len0", 32'(pkt_busy), 1);
    rd(8'h5A, 1);
    chk("t5_busy_done", 32'(pkt_busy), 0);
    // reset dominates everything
    wr(0, 8'h31); wr(0, 8'h32); rd(8'h31, 0);
    reset = 1; soft_reset = 1; write_enb = 1; read_enb = 1; data_in = 8'hC3;
    step();
    reset = 0; soft_reset = 0; write_enb = 0; read_enb = 0;
    chk_reset_vals("t6_reset");
    step(); step();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
